// File: rtl/bufc_port_arbiter.sv
// Buffer-C port arbiter: grants whole ACC / LD / ST bursts on the single buffer-C
// read/write port pair and generates every buffer address, write enable and mux select.
module bufc_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 9,
    parameter int ACC_LAT = 3,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              acc_req,
    input  logic [ADDR_W-1:0] acc_base,
    input  logic [LEN_W-1:0]  acc_len,
    input  logic              acc_beat,
    output logic              acc_gnt,
    output logic              acc_done,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [LEN_W-1:0]  ld_len,
    input  logic              ld_beat,
    output logic              ld_gnt,
    output logic              ld_done,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_base,
    input  logic [LEN_W-1:0]  st_len,
    input  logic              st_ready,
    output logic              st_gnt,
    output logic              st_done,
    output logic              st_valid,
    output logic [ADDR_W-1:0] bufc_raddr,
    output logic [ADDR_W-1:0] bufc_waddr,
    output logic              bufc_wren,
    output logic              load_sel,
    output logic              store_sel,
    output logic              err_len0
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACC, S_LD, S_ST, S_DRAIN_ACC, S_DRAIN_ST
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [1:0]        r_acc_streak;
    logic              r_acc_gnt, r_ld_gnt, r_st_gnt;
    logic              r_load_sel, r_store_sel;
    logic              r_acc_done, r_ld_done, r_st_done;
    logic              r_err_len0;
    logic [ADDR_W-1:0] r_raddr;
    logic [ACC_LAT-1:0] r_wb_vld;
    logic [ADDR_W-1:0] r_wb_addr [ACC_LAT];
    logic [RD_LAT-1:0] r_rd_vld;

    logic              w_guard, w_pick_acc, w_pick_ld, w_pick_st, w_pick_any;
    logic [ADDR_W-1:0] w_pick_base;
    logic [LEN_W-1:0]  w_pick_len;
    logic [ADDR_W-1:0] w_addr;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic              w_last;
    logic              w_acc_issue, w_ld_write, w_st_issue;
    logic              w_wb_pending, w_rd_pending;

    // After two back-to-back ACC grants a waiting LD or ST takes the next slot.
    assign w_guard    = (r_acc_streak == 2'd2) && (ld_req || st_req);
    assign w_pick_acc = acc_req && !w_guard;
    assign w_pick_ld  = ld_req && !w_pick_acc;
    assign w_pick_st  = st_req && !w_pick_acc && !ld_req;
    assign w_pick_any = w_pick_acc || w_pick_ld || w_pick_st;

    always_comb begin
        w_pick_base = acc_base;
        w_pick_len  = acc_len;
        if (w_pick_ld) begin
            w_pick_base = ld_base;
            w_pick_len  = ld_len;
        end else if (w_pick_st) begin
            w_pick_base = st_base;
            w_pick_len  = st_len;
        end
    end

    assign w_addr      = r_base + r_cnt[ADDR_W-1:0];
    assign w_cnt_nxt   = r_cnt + LEN_W'(1);
    assign w_last      = (w_cnt_nxt == r_len);
    assign w_acc_issue = (r_state == S_ACC) && acc_beat;
    assign w_ld_write  = (r_state == S_LD) && ld_beat;
    assign w_st_issue  = (r_state == S_ST) && st_ready;

    // Entries still travelling below the output stage of each pipe.
    assign w_wb_pending = |(r_wb_vld << 1);
    assign w_rd_pending = |(r_rd_vld << 1);

    assign bufc_raddr = (w_acc_issue || w_st_issue) ? w_addr : r_raddr;
    assign bufc_wren  = w_ld_write || r_wb_vld[ACC_LAT-1];
    assign bufc_waddr = w_ld_write ? w_addr : r_wb_addr[ACC_LAT-1];
    assign st_valid   = r_rd_vld[RD_LAT-1];

    assign acc_gnt   = r_acc_gnt;
    assign ld_gnt    = r_ld_gnt;
    assign st_gnt    = r_st_gnt;
    assign load_sel  = r_load_sel;
    assign store_sel = r_store_sel;
    assign acc_done  = r_acc_done;
    assign ld_done   = r_ld_done;
    assign st_done   = r_st_done;
    assign err_len0  = r_err_len0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wb_vld <= '0;
            r_rd_vld <= '0;
            r_raddr  <= '0;
            for (int i = 0; i < ACC_LAT; i++) r_wb_addr[i] <= '0;
        end else begin
            r_wb_vld     <= (r_wb_vld << 1) | ACC_LAT'(w_acc_issue);
            r_rd_vld     <= (r_rd_vld << 1) | RD_LAT'(w_st_issue);
            r_wb_addr[0] <= w_addr;
            for (int i = 1; i < ACC_LAT; i++) r_wb_addr[i] <= r_wb_addr[i-1];
            if (w_acc_issue || w_st_issue) r_raddr <= w_addr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_acc_streak <= '0;
            r_acc_gnt    <= 1'b0;
            r_ld_gnt     <= 1'b0;
            r_st_gnt     <= 1'b0;
            r_load_sel   <= 1'b0;
            r_store_sel  <= 1'b0;
            r_acc_done   <= 1'b0;
            r_ld_done    <= 1'b0;
            r_st_done    <= 1'b0;
            r_err_len0   <= 1'b0;
        end else begin
            r_acc_done <= 1'b0;
            r_ld_done  <= 1'b0;
            r_st_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_any) begin
                        if (w_pick_acc)
                            r_acc_streak <= (r_acc_streak == 2'd2) ? 2'd2 : r_acc_streak + 2'd1;
                        else
                            r_acc_streak <= 2'd0;
                        // A zero-length burst never touches the port; it only completes.
                        if (w_pick_len == '0) begin
                            r_err_len0 <= 1'b1;
                            r_acc_done <= w_pick_acc;
                            r_ld_done  <= w_pick_ld;
                            r_st_done  <= w_pick_st;
                        end else begin
                            r_base      <= w_pick_base;
                            r_len       <= w_pick_len;
                            r_cnt       <= '0;
                            r_state     <= w_pick_acc ? S_ACC : (w_pick_ld ? S_LD : S_ST);
                            r_acc_gnt   <= w_pick_acc;
                            r_ld_gnt    <= w_pick_ld;
                            r_load_sel  <= w_pick_ld;
                            r_st_gnt    <= w_pick_st;
                            r_store_sel <= w_pick_st;
                        end
                    end
                end
                S_ACC: begin
                    if (acc_beat) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_state   <= S_DRAIN_ACC;
                            r_acc_gnt <= 1'b0;
                        end
                    end
                end
                S_DRAIN_ACC: begin
                    if (!w_wb_pending) begin
                        r_state    <= S_IDLE;
                        r_acc_done <= 1'b1;
                    end
                end
                S_LD: begin
                    if (ld_beat) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_state    <= S_IDLE;
                            r_ld_gnt   <= 1'b0;
                            r_load_sel <= 1'b0;
                            r_ld_done  <= 1'b1;
                        end
                    end
                end
                S_ST: begin
                    if (st_ready) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_last) begin
                            r_state  <= S_DRAIN_ST;
                            r_st_gnt <= 1'b0;
                        end
                    end
                end
                S_DRAIN_ST: begin
                    if (!w_rd_pending) begin
                        r_state     <= S_IDLE;
                        r_store_sel <= 1'b0;
                        r_st_done   <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bufc_port_arbiter.md
Name: bufc_port_arbiter

Overview:
- Sequences and shares the single read/write port pair of the output buffer (buffer C) among three requesters:
  - accumulator read-modify-write pass (ACC),
  - AXI-C load into buffer (LD),
  - AXI-C store out of buffer (ST).
- Grants whole bursts and generates all buffer addresses and write enables.
- Drives the load/store mode selects that steer the buffer-C muxes in the top level.
- Sits between the Controller's burst requests and the buffer-C steering logic.

Parameters:
- ADDR_W, 8, buffer-C address width, equal to $clog2(OUT_BUFFER_SIZE).
- LEN_W, 9, burst-length field width; a burst covers 1..2^ADDR_W entries.
- ACC_LAT, 3, cycles from accumulator read address issue to its write-back.
- RD_LAT, 1, buffer-C read latency.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- acc_req  in  1  ACC burst request; held until acc_done
- acc_base  in  ADDR_W  ACC start address
- acc_len  in  LEN_W  ACC beat count
- acc_beat  in  1  accumulator presents a beat this cycle, only while acc_gnt
- acc_gnt  out  1  ACC owns the port
- acc_done  out  1  one-cycle pulse after the last ACC write-back
- ld_req / ld_base / ld_len  in  1/ADDR_W/LEN_W  LD burst request
- ld_beat  in  1  buffered load data valid this cycle
- ld_gnt / ld_done  out  1/1  LD grant and completion pulse
- st_req / st_base / st_len  in  1/ADDR_W/LEN_W  ST burst request
- st_ready  in  1  consumer accepts one read issued this cycle
- st_gnt / st_done  out  1/1  ST grant and completion pulse
- st_valid  out  1  buffer-C read data valid for the consumer
- bufc_raddr  out  ADDR_W  buffer-C read address
- bufc_waddr  out  ADDR_W  buffer-C write address
- bufc_wren  out  1  buffer-C write enable
- load_sel  out  1  maps to axi_C_load_to_buffer_C
- store_sel  out  1  maps to axi_C_store_from_buffer_C
- err_len0  out  1  sticky flag: a zero-length request was seen

Behaviour:
- Reset (rstn low, asynchronous): every output is 0, FSM goes to IDLE, all counters clear. Reset asserted mid-burst aborts the burst and emits no done pulse.
- FSM states: IDLE, ACC, LD, ST, DRAIN_ACC, DRAIN_ST.
- IDLE: arbitrate on registered requests with priority ACC > LD > ST.
  - Starvation guard: after 2 consecutive ACC grants, a pending ST or LD wins next.
  - Grant takes effect the cycle after req is sampled.
  - base and len are latched at grant; requester inputs are then don't-care until done.
- Zero length: the request is ignored, err_len0 sets, and the done pulse is issued the next cycle with no port activity.
- ACC:
  - Each acc_beat drives bufc_raddr = base + count.
  - The same address is written ACC_LAT cycles later with bufc_wren = 1, via an address/valid shift pipe.
  - load_sel = 0, store_sel = 0.
  - After len beats, go to DRAIN_ACC. Hold there until the pipe is empty, then pulse acc_done and return to IDLE.
- LD:
  - load_sel = 1.
  - Each ld_beat writes bufc_waddr = base + count with bufc_wren = 1 in the same cycle.
  - The last beat pulses ld_done the next cycle and returns to IDLE.
  - ld_beat outside LD is ignored.
- ST:
  - store_sel = 1.
  - When st_ready is high, issue a read at base + count.
  - st_valid follows each issued read after RD_LAT cycles.
  - st_ready low stalls the counter with no read issued.
  - After len reads, go to DRAIN_ST. When the last st_valid is out, pulse st_done and return to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around past the top entry is legal and silent.
- bufc_wren is never asserted in ST. bufc_raddr holds its last value when idle.
- A new request can be sampled in the same cycle a done pulse is emitted. Back-to-back grants therefore have exactly 1 idle cycle between them.
- Requests dropping before their grant are withdrawn, with no side effects.
- acc_beat arriving in a cycle without a grant is ignored.

Test Plan:
- ACC base=10, len=4, beats every cycle, ACC_LAT=3 -> raddr 10..13 on cycles 1..4; wren with waddr 10..13 on cycles 4..7; acc_done pulses on cycle 8.
- LD base=0xFE, len=4, ld_beat gapped 1-on/1-off -> waddr FE, FF, 00, 01 (wrap); ld_done one cycle after the 4th beat; load_sel high throughout.
- ST base=5, len=3, st_ready low on the 2nd cycle -> raddr 5, 6, 7 with a 1-cycle stall; st_valid 3 pulses; store_sel high; wren stays 0.
- ACC, LD and ST all requested together, ACC re-requesting continuously -> grant order ACC, ACC, LD, ACC, ACC, ST; never more than 2 consecutive ACC grants while ST or LD pends.
- rstn dropped mid-ACC at beat 2 -> all outputs 0 asynchronously, no acc_done; after release, a fresh ST len=1 completes normally.
- ld_len=0 -> no wren, err_len0 = 1 (sticky), ld_done pulses once.
